// File: rtl/act_vec_serializer.sv
// act_vec_serializer: captures a flat activation vector in one handshake and
// streams it as WORD_BITS beats. ACT_SER_DOUBLE_BUFFER_EN adds a shadow vector.
module act_vec_serializer #(
  parameter int NUM_NEURONS = 128,
  parameter int ACT_BITS    = 2,
  parameter int WORD_BITS   = 16,
  localparam int VEC_BITS   = NUM_NEURONS * ACT_BITS,
  localparam int NBEATS     = (VEC_BITS + WORD_BITS - 1) / WORD_BITS,
  localparam int IDX_BITS   = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [VEC_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_BITS-1:0] out_data,
  output logic                out_last,
  output logic [IDX_BITS-1:0] out_index
);

  localparam int PAD_BITS = NBEATS * WORD_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX =
    IDX_BITS'(NBEATS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e state_q, state_d;
  logic [NBEATS-1:0][WORD_BITS-1:0] cap_q, cap_d;
  logic [NBEATS-1:0][WORD_BITS-1:0] in_pad;
  logic [IDX_BITS-1:0] beat_q, beat_d;
  logic in_fire, out_fire, last_beat;

`ifdef ACT_SER_DOUBLE_BUFFER_EN
  logic [NBEATS-1:0][WORD_BITS-1:0] shadow_q, shadow_d;
  logic shadow_full_q, shadow_full_d;
`endif

  // Zero-extend so padding bits of the final beat read as 0
  assign in_pad    = PAD_BITS'(in_data);
  assign last_beat = (beat_q == LAST_IDX);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      beat_q  <= '0;
`ifdef ACT_SER_DOUBLE_BUFFER_EN
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      beat_q  <= beat_d;
`ifdef ACT_SER_DOUBLE_BUFFER_EN
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    beat_d  = beat_q;
`ifdef ACT_SER_DOUBLE_BUFFER_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          cap_d   = in_pad;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_fire && last_beat) begin
          beat_d  = '0;
          state_d = IDLE;
`ifdef ACT_SER_DOUBLE_BUFFER_EN
          // Queued vector starts with no idle gap
          if (shadow_full_q) begin
            cap_d         = shadow_q;
            shadow_full_d = 1'b0;
            state_d       = SEND;
          end else if (in_fire) begin
            cap_d   = in_pad;
            state_d = SEND;
          end
`endif
        end else begin
          if (out_fire) begin
            beat_d = beat_q + IDX_BITS'(1);
          end
`ifdef ACT_SER_DOUBLE_BUFFER_EN
          if (in_fire) begin
            shadow_d      = in_pad;
            shadow_full_d = 1'b1;
          end
`endif
        end
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_index = beat_q;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SEND: begin
`ifdef ACT_SER_DOUBLE_BUFFER_EN
        in_ready = ~shadow_full_q;
`else
        in_ready = 1'b0;
`endif
        out_valid = 1'b1;
        out_data  = cap_q[beat_q];
        out_last  = last_beat;
      end
    endcase
  end

endmodule

// File: tb/tb_act_vec_serializer.sv
// Bench for act_vec_serializer: queue model of expected beats plus
// directed literal checks, both buffer configurations.
module tb_act_vec_serializer;

  localparam int NN  = 128;
  localparam int AB  = 2;
  localparam int WB  = 16;
  localparam int VEC = NN * AB;
  localparam int NB  = (VEC + WB - 1) / WB;
`ifdef ACT_SER_DOUBLE_BUFFER_EN
  localparam int CAP_LIM = NB;
  localparam int BB_CYC  = 32;
  localparam int BUSY16  = 0;
`else
  localparam int CAP_LIM = 0;
  localparam int BB_CYC  = 33;
  localparam int BUSY16  = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [VEC-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [WB-1:0] out_data;
  logic out_last;
  logic [3:0] out_index;

  logic in_valid_b = 1'b0;
  logic in_ready_b;
  logic [19:0] in_data_b = '0;
  logic out_valid_b;
  logic out_ready_b = 1'b0;
  logic [15:0] out_data_b;
  logic out_last_b;
  logic [0:0] out_index_b;

  act_vec_serializer #(
    .NUM_NEURONS(NN), .ACT_BITS(AB), .WORD_BITS(WB)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .out_index(out_index)
  );

  act_vec_serializer #(
    .NUM_NEURONS(10), .ACT_BITS(2), .WORD_BITS(16)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_last(out_last_b),
    .out_index(out_index_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [WB-1:0] d;
    int            idx;
    bit            last;
  } beat_t;

  function automatic logic [WB-1:0] beat_of(
    logic [VEC-1:0] v, int b);
    logic [WB-1:0] w;
    w = '0;
    for (int k = 0; k < WB; k++)
      if (b * WB + k < VEC) w[k] = v[b * WB + k];
    return w;
  endfunction

  beat_t q[$];
  beat_t log_q[$];
  int    busy = 0;
  int    acc  = 0;
  bit    armed = 1'b0;

  // Expected stream: every captured vector adds NB beats;
  // in_ready reflects how many vectors are outstanding.
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", in_ready, (q.size() <= CAP_LIM));
      chk("out_valid", out_valid, (q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_index", out_index, q[0].idx);
        chk("out_last", out_last, q[0].last);
      end
      if (!in_ready) busy++;
      if (rst) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          log_q.push_back('{out_data, int'(out_index),
                           out_last});
          acc++;
          if (q.size() != 0) void'(q.pop_front());
        end
        if (in_valid && in_ready)
          for (int b = 0; b < NB; b++)
            q.push_back('{beat_of(in_data, b), b,
                          (b == NB - 1)});
      end
    end
  end

  task automatic capture(input logic [VEC-1:0] v);
    in_data  = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_done"}, (n < 200), 1);
  endtask

  function automatic logic [VEC-1:0] rand_vec();
    logic [VEC-1:0] v;
    for (int i = 0; i < VEC / 32; i++)
      v[i * 32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [VEC-1:0] v;
    logic [WB-1:0]  hold;
    int base, bbase, abase;
    bit hs;

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_b_valid", out_valid_b, 0);
    armed = 1'b1;

    // Basic: neuron n = n mod 4 gives E4 per byte
    for (int n = 0; n < NN; n++) v[n * AB +: AB] = 2'(n % 4);
    out_ready = 1'b1;
    base  = log_q.size();
    bbase = busy;
    capture(v);
    wait_idle("basic");
    chk("basic_nbeats", log_q.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < log_q.size()) begin
        chk("basic_data", log_q[base + i].d, 16'hE4E4);
        chk("basic_idx", log_q[base + i].idx, i);
        chk("basic_last", log_q[base + i].last, (i == 15));
      end
    end
    chk("basic_busy", busy - bbase, BUSY16);

    // Backpressure at beat 3
    base = log_q.size();
    capture(rand_vec());
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    hold = out_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_idx", out_index, 3);
      chk("bp_last", out_last, 0);
      chk("bp_data", out_data, hold);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_idle("bp");
    chk("bp_nbeats", log_q.size() - base, 16);

    // Input isolation with random stalls
    v = rand_vec();
    base = log_q.size();
    capture(v);
    for (int c = 0; c < 30; c++) begin
      in_data   = rand_vec();
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle("iso");
    chk("iso_nbeats", log_q.size() - base, 16);
    for (int i = 0; i < 16; i++)
      if (base + i < log_q.size())
        chk("iso_data", log_q[base + i].d, v[i * WB +: WB]);

    // Reset while beat 7 is presented
    capture(rand_vec());
    repeat (7) @(posedge clk);
    #1;
    chk("mid_idx7", out_index, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_valid", out_valid, 0);
    chk("mid_ready", in_ready, 1);
    chk("mid_idx", out_index, 0);
    base = log_q.size();
    capture(rand_vec());
    wait_idle("mid");
    chk("mid_nbeats", log_q.size() - base, 16);
    if (log_q.size() - base == 16) begin
      chk("mid_first", log_q[base].idx, 0);
      chk("mid_lastf", log_q[base + 15].last, 1);
    end

    // Back-to-back A then B, B held until accepted
    abase = acc;
    capture(rand_vec());
    in_data  = rand_vec();
    in_valid = 1'b1;
    for (int c = 1; c <= BB_CYC; c++) begin
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) in_valid = 1'b0;
      if (c == BB_CYC - 1) chk("bb_busy", out_valid, 1);
    end
    chk("bb_in_valid", in_valid, 0);
    chk("bb_done", out_valid, 0);
    chk("bb_beats", acc - abase, 32);

    // Padding: 10 neurons x 2 bits over 16-bit beats
    in_data_b   = '1;
    in_valid_b  = 1'b1;
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    chk("pad_v0", out_valid_b, 1);
    chk("pad_d0", out_data_b, 16'hFFFF);
    chk("pad_l0", out_last_b, 0);
    chk("pad_i0", out_index_b, 0);
    @(posedge clk); #1;
    chk("pad_v1", out_valid_b, 1);
    chk("pad_d1", out_data_b, 16'h000F);
    chk("pad_l1", out_last_b, 1);
    chk("pad_i1", out_index_b, 1);
    @(posedge clk); #1;
    chk("pad_end", out_valid_b, 0);
    chk("pad_rdy", in_ready_b, 1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_vec_serializer.md
Name: act_vec_serializer

Overview:
- Sits after the last LUT-neuron layer of the quantized autoencoder.
- Captures the flat, combinationally produced activation bus (NUM_NEURONS × ACT_BITS bits) in one handshake.
- Emits the bus as a stream of WORD_BITS-wide beats with valid/ready and a last flag, for the off-chip link or the decoder-side deserializer.
- Read-side counterpart of the per-neuron output packing: wide parallel writer in, narrow ordered reader stream out.

Parameters:
- NUM_NEURONS, 128, neurons whose outputs form the captured vector
- ACT_BITS, 2, bits per neuron activation
- WORD_BITS, 16, output beat width; must be a multiple of ACT_BITS
- Derived: VEC_BITS = NUM_NEURONS*ACT_BITS; NBEATS = ceil(VEC_BITS/WORD_BITS); IDX_BITS = max(1, clog2(NBEATS))

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  in_data holds a complete activation vector
- in_ready  out  1  block can capture a vector this cycle
- in_data  in  VEC_BITS  neuron n at bits [n*ACT_BITS +: ACT_BITS]
- out_valid  out  1  out_data holds a beat
- out_ready  in  1  downstream accepts the beat
- out_data  out  WORD_BITS  current beat
- out_last  out  1  high on the final beat of a vector
- out_index  out  IDX_BITS  beat number within the vector, 0..NBEATS-1

Behaviour:
- Reset (one cycle of rst=1) gives: out_valid=0, out_last=0, out_index=0, out_data=0, in_ready=1, state IDLE, capture register cleared. Reset mid-vector abandons the vector and emits no further beats.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch in_data into cap_reg, set beat counter=0, go to SEND.
  - SEND: in_ready=0. out_valid=1. out_data = cap_reg[beat*WORD_BITS +: WORD_BITS]. Bits beyond VEC_BITS in the final beat are 0. out_index = beat. out_last = (beat == NBEATS-1).
    - On out_valid&&out_ready with beat < NBEATS-1: beat+1.
    - On out_valid&&out_ready on the last beat: go to IDLE.
- Latency: first beat is valid the cycle after capture. With out_ready held at 1, one beat per cycle. A vector occupies NBEATS cycles plus 1 IDLE cycle, i.e. throughput is 1 vector per NBEATS+1 cycles.
- Holding rules:
  - While out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable.
  - out_valid never drops before its beat is accepted.
- in_data is sampled only on the capture cycle. Changes to it afterwards do not affect beats in flight.
- Ordering: beat 0 carries neuron 0 in its LSBs. Each beat carries WORD_BITS/ACT_BITS neurons in ascending order.
- NBEATS=1 is legal: every beat has out_last=1 and out_index=0.
- in_valid asserted during SEND is ignored; the upstream producer holds its data until in_ready.
- The output stream has no bubbles within a vector when out_ready=1.

Optional Feature:
- Macro: ACT_SER_DOUBLE_BUFFER_EN.
- Defined:
  - Adds a shadow vector register.
  - in_ready = !shadow_full, including during SEND.
  - A vector captured during SEND is moved to cap_reg on the cycle the last beat is accepted, and its beat 0 appears the next cycle without an IDLE gap. Throughput is 1 vector per NBEATS cycles.
  - Capture and last-beat acceptance in the same cycle is legal: the new vector goes straight to cap_reg.
  - rst clears shadow_full.
- Undefined: no shadow register; behaviour exactly as above.

Test Plan:
- Basic (NUM_NEURONS=128, WORD_BITS=16): in_data with neuron n = n mod 4, out_ready=1. Expect 16 beats, each out_data=16'hE4E4, out_index 0..15, out_last only on beat 15, in_ready low for those 16 cycles.
- Backpressure: hold out_ready=0 for 5 cycles at beat 3. Expect out_data, out_index=3 and out_last=0 stable. On resume, beats 4..15 follow with none dropped or duplicated.
- Padding (NUM_NEURONS=10, WORD_BITS=16, VEC_BITS=20): all-ones input. Expect 2 beats: 16'hFFFF, then 16'h000F with out_last=1.
- Reset mid-vector: assert rst at beat 7 for 1 cycle. Expect next cycle out_valid=0, in_ready=1, out_index=0. A fresh vector then restarts at beat 0.
- Input isolation: change in_data every cycle during SEND. Expect the emitted beats to equal the vector present at capture.
- Double buffer (ACT_SER_DOUBLE_BUFFER_EN): two back-to-back vectors A and B, out_ready=1. Expect in_ready=1 during A's SEND, B's beat 0 on the cycle after A's last beat, 32 beats total in 33 cycles from the first capture.
